// File: rtl/uart_rx_terminal.sv
// uart_rx_terminal: 8N1 serial receiver with mid-bit sampling, start-glitch
// rejection, framing-error/break handling and a one-byte valid/ready hold stage.
module uart_rx_terminal #(
   parameter int unsigned CLKS_PER_BIT = 10408,
   parameter int unsigned DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned IDX_W = 3;
   localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   logic [1:0]           sync_q;
   logic                 rx_s;
   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] data_out_q, data_out_d;
   logic                 valid_q, valid_d;
   logic                 fe_q, fe_d;
   logic                 ov_q, ov_d;
   logic                 busy_q, busy_d;
   logic                 tick;
   logic                 done;

   assign rx_s       = sync_q[1];
   assign tick       = (cnt_q == '0);
   assign data_out   = data_out_q;
   assign data_valid = valid_q;
   assign frame_err  = fe_q;
   assign overrun    = ov_q;
   assign busy       = busy_q;

   // Two-flop synchroniser for the asynchronous serial line; resets to idle-high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], rx};
   end

   // State, counters and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shreg_q    <= '0;
         data_out_q <= '0;
         valid_q    <= 1'b0;
         fe_q       <= 1'b0;
         ov_q       <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shreg_q    <= shreg_d;
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
         fe_q       <= fe_d;
         ov_q       <= ov_d;
         busy_q     <= busy_d;
      end
   end

   // Next-state, bit timing, shifting and hold-stage handshake.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      shreg_d    = shreg_q;
      data_out_d = data_out_q;
      valid_d    = valid_q;
      fe_d       = 1'b0;
      ov_d       = 1'b0;
      done       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
               cnt_d   = HALF_RELOAD;
            end
         end
         S_START: begin
            if (tick) begin
               if (!rx_s) begin
                  state_d = S_DATA;
                  idx_d   = '0;
                  cnt_d   = FULL_RELOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DATA: begin
            if (tick) begin
               shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
               cnt_d   = FULL_RELOAD;
               if (idx_q == LAST_IDX) state_d = S_STOP;
               else                   idx_d   = idx_q + IDX_W'(1);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_STOP: begin
            if (tick) begin
               cnt_d = FULL_RELOAD;
               if (rx_s) begin
                  done    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_BREAK: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A completed byte either fills the hold stage, replaces a byte being
      // consumed this cycle, or is dropped with an overrun pulse.
      if (done) begin
         if (!valid_q || data_ready) begin
            data_out_d = shreg_q;
            valid_d    = 1'b1;
         end else begin
            ov_d = 1'b1;
         end
      end else if (valid_q && data_ready) begin
         valid_d = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
   end

endmodule

// File: tb/tb_uart_rx_terminal.sv
// Directed bench for uart_rx_terminal: one instance at 16 clks/bit for the
// functional cases and one at 1000 clks/bit for the +/-1% baud tolerance case.
module tb_uart_rx_terminal;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx, rx2;
   logic [7:0] data_out, data_out2;
   logic       data_valid, data_valid2;
   logic       data_ready, data_ready2;
   logic       frame_err, frame_err2;
   logic       overrun, overrun2;
   logic       busy, busy2;

   int n_tests = 0;
   int n_fail  = 0;

   // Monitor counters for the 16-clk instance.
   int cyc = 0, xfer = 0, fe_cnt = 0, ov_cnt = 0, busy_hi = 0, rises = 0;
   int last_rise = 0, prev_rise = 0;
   logic [7:0] last_byte = 8'h00;
   logic prev_valid = 1'b0;
   // Monitor counters for the 1000-clk instance.
   int xfer2 = 0, fe2_cnt = 0, ov2_cnt = 0;
   logic [7:0] last_byte2 = 8'h00;

   always #5 clk = ~clk;

   uart_rx_terminal #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
      .clk(clk), .rst(rst), .rx(rx),
      .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
      .frame_err(frame_err), .overrun(overrun), .busy(busy)
   );

   uart_rx_terminal #(.CLKS_PER_BIT(1000), .DATA_BITS(8)) dut2 (
      .clk(clk), .rst(rst), .rx(rx2),
      .data_out(data_out2), .data_valid(data_valid2), .data_ready(data_ready2),
      .frame_err(frame_err2), .overrun(overrun2), .busy(busy2)
   );

   // Event counters sampled on the active edge (pre-update values of the DUT).
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (data_valid && data_ready) begin
         xfer      <= xfer + 1;
         last_byte <= data_out;
      end
      if (frame_err) fe_cnt  <= fe_cnt + 1;
      if (overrun)   ov_cnt  <= ov_cnt + 1;
      if (busy)      busy_hi <= busy_hi + 1;
      if (data_valid && !prev_valid) begin
         rises     <= rises + 1;
         prev_rise <= last_rise;
         last_rise <= cyc;
      end
      prev_valid <= data_valid;
      if (data_valid2 && data_ready2) begin
         xfer2      <= xfer2 + 1;
         last_byte2 <= data_out2;
      end
      if (frame_err2) fe2_cnt <= fe2_cnt + 1;
      if (overrun2)   ov2_cnt <= ov2_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input int which, input logic v, input int n);
      if (which == 0) rx = v;
      else            rx2 = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input int which, input logic [7:0] b, input int cpb, input logic stop_bit);
      drive_bit(which, 1'b0, cpb);
      for (int i = 0; i < 8; i++) drive_bit(which, b[i], cpb);
      drive_bit(which, stop_bit, cpb);
   endtask

   int s_xfer, s_fe, s_ov, s_busy, s_rises, s_xfer2, s_fe2, s_ov2;

   task automatic snap();
      s_xfer  = xfer;   s_fe  = fe_cnt;  s_ov  = ov_cnt;
      s_busy  = busy_hi; s_rises = rises;
      s_xfer2 = xfer2;  s_fe2 = fe2_cnt; s_ov2 = ov2_cnt;
   endtask

   initial begin
      rst = 1'b1; rx = 1'b1; rx2 = 1'b1; data_ready = 1'b0; data_ready2 = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Reset state
      check("rst_data_out",   32'(data_out),   32'h0);
      check("rst_data_valid", 32'(data_valid), 32'h0);
      check("rst_frame_err",  32'(frame_err),  32'h0);
      check("rst_overrun",    32'(overrun),    32'h0);
      check("rst_busy",       32'(busy),       32'h0);
      check("rst_busy2",      32'(busy2),      32'h0);

      // 1: repeating 12-bit pattern carrying 0x55, consumer always ready
      data_ready = 1'b1;
      snap();
      for (int f = 0; f < 4; f++) begin
         drive_bit(0, 1'b1, 16); drive_bit(0, 1'b1, 16);
         drive_bit(0, 1'b0, 16);
         for (int i = 0; i < 4; i++) begin
            drive_bit(0, 1'b1, 16); drive_bit(0, 1'b0, 16);
         end
         drive_bit(0, 1'b1, 16);
      end
      repeat (4) @(negedge clk);
      check("t1_xfers",    32'(xfer - s_xfer),      32'd4);
      check("t1_byte",     32'(last_byte),          32'h55);
      check("t1_period",   32'(last_rise - prev_rise), 32'd192);
      check("t1_no_fe",    32'(fe_cnt - s_fe),      32'd0);
      check("t1_no_ov",    32'(ov_cnt - s_ov),      32'd0);

      // 2: two back-to-back frames while the consumer is stalled
      data_ready = 1'b0;
      snap();
      send_frame(0, 8'hA3, 16, 1'b1);
      send_frame(0, 8'h5C, 16, 1'b1);
      repeat (4) @(negedge clk);
      check("t2_overrun_once", 32'(ov_cnt - s_ov), 32'd1);
      check("t2_held_byte",    32'(data_out),      32'hA3);
      check("t2_valid_held",   32'(data_valid),    32'h1);
      check("t2_no_fe",        32'(fe_cnt - s_fe), 32'd0);
      data_ready = 1'b1;
      @(negedge clk);
      check("t2_valid_cleared", 32'(data_valid),      32'h0);
      check("t2_byte_kept",     32'(data_out),        32'hA3);
      check("t2_one_xfer",      32'(xfer - s_xfer),   32'd1);
      check("t2_xfer_byte",     32'(last_byte),       32'hA3);

      // 3: 6-clk low glitch is rejected
      snap();
      drive_bit(0, 1'b0, 6);
      drive_bit(0, 1'b1, 30);
      check("t3_busy_seen", 32'((busy_hi - s_busy) != 0), 32'h1);
      check("t3_busy_low",  32'(busy),                    32'h0);
      check("t3_no_valid",  32'(data_valid),              32'h0);
      check("t3_no_fe",     32'(fe_cnt - s_fe),           32'd0);
      check("t3_no_xfer",   32'(xfer - s_xfer),           32'd0);

      // 4: framing error, break, then a good frame
      snap();
      send_frame(0, 8'h33, 16, 1'b0);
      drive_bit(0, 1'b0, 100);
      drive_bit(0, 1'b1, 32);
      send_frame(0, 8'h0F, 16, 1'b1);
      drive_bit(0, 1'b1, 16);
      check("t4_one_fe",   32'(fe_cnt - s_fe),     32'd1);
      check("t4_one_rise", 32'(rises - s_rises),   32'd1);
      check("t4_one_xfer", 32'(xfer - s_xfer),     32'd1);
      check("t4_byte",     32'(last_byte),         32'h0F);
      check("t4_data_out", 32'(data_out),          32'h0F);
      check("t4_no_ov",    32'(ov_cnt - s_ov),     32'd0);

      // 5: asynchronous reset in the middle of bit 4 of 0xF5
      drive_bit(0, 1'b0, 16);
      for (int i = 0; i < 4; i++) drive_bit(0, (i % 2 == 0) ? 1'b1 : 1'b0, 16);
      drive_bit(0, 1'b1, 8);
      check("t5_busy_before", 32'(busy), 32'h1);
      rst = 1'b1;
      #1;
      check("t5_rst_data_out", 32'(data_out),   32'h0);
      check("t5_rst_valid",    32'(data_valid), 32'h0);
      check("t5_rst_fe",       32'(frame_err),  32'h0);
      check("t5_rst_ov",       32'(overrun),    32'h0);
      check("t5_rst_busy",     32'(busy),       32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      snap();
      drive_bit(0, 1'b1, 16 * 5);
      send_frame(0, 8'hC6, 16, 1'b1);
      drive_bit(0, 1'b1, 16);
      check("t5_one_xfer", 32'(xfer - s_xfer), 32'd1);
      check("t5_byte",     32'(last_byte),     32'hC6);
      check("t5_no_fe",    32'(fe_cnt - s_fe), 32'd0);

      // 6: 1000 clks/bit receiver, transmitter 1% fast then 1% slow
      snap();
      drive_bit(1, 1'b1, 50);
      send_frame(1, 8'h41, 990, 1'b1);
      drive_bit(1, 1'b1, 200);
      check("t6_fast_xfer", 32'(xfer2 - s_xfer2), 32'd1);
      check("t6_fast_byte", 32'(last_byte2),      32'h41);
      snap();
      send_frame(1, 8'h41, 1010, 1'b1);
      drive_bit(1, 1'b1, 200);
      check("t6_slow_xfer", 32'(xfer2 - s_xfer2), 32'd1);
      check("t6_slow_byte", 32'(last_byte2),      32'h41);
      check("t6_no_fe",     32'(fe2_cnt),         32'd0);
      check("t6_no_ov",     32'(ov2_cnt),         32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
